// File: rtl/led_pattern_pkg.sv
// Shared mode encoding and default sizing for the LED pattern counter.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    BINARY = 2'd0,
    GRAY   = 2'd1,
    SCAN   = 2'd2,
    BLINK  = 2'd3
  } led_mode_e;

  localparam int unsigned DEF_NUM_LEDS        = 4;
  localparam int unsigned DEF_PRESCALE_MAX    = 12_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 240_000;

  // Cyclic mode advance: BINARY -> GRAY -> SCAN -> BLINK -> BINARY.
  function automatic led_mode_e next_mode(input led_mode_e m);
    return led_mode_e'(2'(m + 2'd1));
  endfunction

endpackage

// File: rtl/led_pattern_counter_if.sv
// Control inputs and display outputs of the LED pattern counter.
interface led_pattern_counter_if
  import led_pattern_pkg::*;
#(
  parameter int unsigned NUM_LEDS = DEF_NUM_LEDS
);
  logic                enable;
  logic                dir;
  logic                mode_btn;
  logic [NUM_LEDS-1:0] gleds;
  logic                rled;
  logic                tick;

  modport master (output enable, dir, mode_btn, input gleds, rled, tick);
  modport slave  (input enable, dir, mode_btn, output gleds, rled, tick);
endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus stable-level debounce; emits one press per debounced rising level.
module button_debouncer
  import led_pattern_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press
);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_raw};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  // Count consecutive disagreeing cycles; any agreement restarts the run.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
        press_d = ~level_q;
      end else begin
        cnt_d = CNT_W'(cnt_q + CNT_W'(1));
      end
    end
  end

  assign btn_level = level_q;
  assign btn_press = press_q;

endmodule

// File: rtl/led_pattern_counter.sv
// Prescaled LED pattern generator with button-selected BINARY/GRAY/SCAN/BLINK modes.
module led_pattern_counter
  import led_pattern_pkg::*;
#(
  parameter int unsigned NUM_LEDS        = DEF_NUM_LEDS,
  parameter int unsigned PRESCALE_MAX    = DEF_PRESCALE_MAX,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input logic                  clk,
  input logic                  reset_n,
  led_pattern_counter_if.slave bus
);
  localparam int unsigned PS_W  = $clog2(PRESCALE_MAX);
  localparam int unsigned POS_W = $clog2(NUM_LEDS);
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE_MAX - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);

  led_mode_e           mode_q, mode_d;
  logic [NUM_LEDS-1:0] val_q, val_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                scan_up_q, scan_up_d;
  logic                phase_q, phase_d;
  logic                wrap_q, wrap_d;
  logic [PS_W-1:0]     ps_q, ps_d;

  logic                btn_level, btn_press;
  logic                mode_step_c;
  logic                tick_c;
  logic [NUM_LEDS-1:0] gleds_c;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn_raw  (bus.mode_btn),
    .btn_level(btn_level),
    .btn_press(btn_press)
  );

  // A press is only acted on while the debounced level is still asserted.
  assign mode_step_c = btn_press & btn_level;
  assign tick_c      = bus.enable && (ps_q == PS_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q    <= BINARY;
      val_q     <= '0;
      pos_q     <= '0;
      scan_up_q <= 1'b1;
      phase_q   <= 1'b0;
      wrap_q    <= 1'b0;
      ps_q      <= '0;
    end else begin
      mode_q    <= mode_d;
      val_q     <= val_d;
      pos_q     <= pos_d;
      scan_up_q <= scan_up_d;
      phase_q   <= phase_d;
      wrap_q    <= wrap_d;
      ps_q      <= ps_d;
    end
  end

  // Mode change wins over a coincident tick and restarts every pattern from its origin.
  always_comb begin
    mode_d    = mode_q;
    val_d     = val_q;
    pos_d     = pos_q;
    scan_up_d = scan_up_q;
    phase_d   = phase_q;
    wrap_d    = wrap_q;
    ps_d      = ps_q;
    if (mode_step_c) begin
      mode_d    = next_mode(mode_q);
      val_d     = '0;
      pos_d     = '0;
      scan_up_d = 1'b1;
      phase_d   = 1'b0;
      wrap_d    = 1'b0;
      ps_d      = '0;
    end else if (bus.enable) begin
      ps_d = tick_c ? '0 : PS_W'(ps_q + PS_W'(1));
      if (tick_c) begin
        val_d   = bus.dir ? NUM_LEDS'(val_q + NUM_LEDS'(1)) : NUM_LEDS'(val_q - NUM_LEDS'(1));
        wrap_d  = ((mode_q == BINARY) || (mode_q == GRAY)) && (bus.dir ? (&val_q) : ~(|val_q));
        phase_d = ~phase_q;
        // Bounce between the end LEDs without repeating them.
        if (scan_up_q) begin
          if (pos_q == POS_LAST) begin
            pos_d     = POS_W'(pos_q - POS_W'(1));
            scan_up_d = 1'b0;
          end else begin
            pos_d = POS_W'(pos_q + POS_W'(1));
          end
        end else begin
          if (pos_q == '0) begin
            pos_d     = POS_W'(1);
            scan_up_d = 1'b1;
          end else begin
            pos_d = POS_W'(pos_q - POS_W'(1));
          end
        end
      end
    end
  end

  // Display decode straight from registered state.
  always_comb begin
    gleds_c = '0;
    case (mode_q)
      BINARY:  gleds_c = val_q;
      GRAY:    gleds_c = val_q ^ (val_q >> 1);
      SCAN:    gleds_c = NUM_LEDS'(1) << pos_q;
      BLINK:   gleds_c = {NUM_LEDS{phase_q}};
      default: gleds_c = '0;
    endcase
  end

  assign bus.gleds = gleds_c;
  assign bus.rled  = wrap_q;
  assign bus.tick  = tick_c;

endmodule

// File: tb/tb_led_pattern_counter.sv
// Randomised scoreboard bench: a behavioural model predicts the display after every step tick.
module tb_led_pattern_counter;
  localparam int N    = 4;
  localparam int P    = 4;
  localparam int D    = 3;
  localparam int MAXV = (1 << N) - 1;

  typedef struct packed {
    logic [N-1:0] gleds;
    logic         rled;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  led_pattern_counter_if #(.NUM_LEDS(N)) bus_if ();

  led_pattern_counter #(
    .NUM_LEDS       (N),
    .PRESCALE_MAX   (P),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_if)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t expq[$];

  // Model state: mode, steps taken since mode entry, counter value, prescale phase, button history.
  int m_presc, m_mode, m_val, m_k, m_ticks = 0, mon_ticks = 0;
  bit m_wrap, m_level, m_press;
  bit m_sync[$];
  bit m_win[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int exp_gleds(input int mode, input int val, input int k);
    int p;
    p = k % (2 * (N - 1));
    if (p >= N) p = 2 * (N - 1) - p;
    case (mode)
      0:       return val;
      1:       return val ^ (val >> 1);
      2:       return 1 << p;
      default: return (k % 2 == 1) ? MAXV : 0;
    endcase
  endfunction

  task automatic model_reset();
    m_presc = 0; m_mode = 0; m_val = 0; m_k = 0;
    m_wrap = 0; m_level = 0; m_press = 0;
    m_sync = {1'b0, 1'b0};
    m_win.delete();
    for (int i = 0; i < D; i++) m_win.push_back(1'b0);
    expq.delete();
  endtask

  task automatic model_step(input bit en, input bit d, input bit raw);
    bit   tick_now, press_now, s, all_diff, dummy;
    exp_t e;
    tick_now  = en && (m_presc == P - 1);
    press_now = m_press;
    // Raw button reaches the debouncer two cycles late; level flips after D disagreeing samples.
    s = m_sync.pop_front();
    m_sync.push_back(raw);
    dummy = m_win.pop_front();
    m_win.push_back(s);
    all_diff = 1'b1;
    foreach (m_win[i]) if (m_win[i] == m_level) all_diff = 1'b0;
    m_press = 1'b0;
    if (all_diff) begin
      m_level = !m_level;
      m_press = m_level;
    end
    if (press_now) begin
      m_mode = (m_mode + 1) % 4;
      m_val = 0; m_k = 0; m_wrap = 0; m_presc = 0;
    end else begin
      if (tick_now) begin
        if (m_mode < 2) m_wrap = d ? (m_val == MAXV) : (m_val == 0);
        else m_wrap = 1'b0;
        m_val = d ? (m_val + 1) % (MAXV + 1) : (m_val + MAXV) % (MAXV + 1);
        m_k++;
      end
      if (en) m_presc = (m_presc + 1) % P;
    end
    if (tick_now) begin
      e.gleds = N'(exp_gleds(m_mode, m_val, m_k));
      e.rled  = m_wrap;
      expq.push_back(e);
      m_ticks++;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!reset_n) model_reset();
      else model_step(bus_if.enable, bus_if.dir, bus_if.mode_btn);
    end
  end

  // Monitor: every DUT tick is followed by a step; compare the display after that edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && bus_if.tick) begin
        @(posedge clk);
        #1;
        mon_ticks++;
        check("tick_expected", int'(expq.size() > 0), 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          check("step_gleds", int'(bus_if.gleds), int'(e.gleds));
          check("step_rled", int'(bus_if.rled), int'(e.rled));
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input int hold, input int gap);
    bus_if.mode_btn = 1'b1;
    cyc(hold);
    bus_if.mode_btn = 1'b0;
    cyc(gap);
  endtask

  initial begin
    int  seg;
    bit  found;
    bus_if.enable   = 1'b0;
    bus_if.dir      = 1'b1;
    bus_if.mode_btn = 1'b0;
    cyc(3);
    check("reset_gleds", int'(bus_if.gleds), 0);
    check("reset_rled", int'(bus_if.rled), 0);
    check("reset_tick", int'(bus_if.tick), 0);

    // Count up through a full wrap, then down for a few steps.
    reset_n = 1'b1;
    bus_if.enable = 1'b1;
    cyc(70);
    bus_if.dir = 1'b0;
    cyc(12);

    // Enable low: display and tick must hold.
    bus_if.enable = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("freeze_tick", int'(bus_if.tick), 0);
      check("freeze_gleds", int'(bus_if.gleds), exp_gleds(m_mode, m_val, m_k));
    end
    @(posedge clk); #2;
    bus_if.enable = 1'b1;
    bus_if.dir = 1'b1;
    cyc(9);

    press(8, 8);
    cyc(40);
    for (int i = 0; i < 6; i++) press($urandom_range(1, 2), $urandom_range(4, 9));
    cyc(20);
    press(50, 30);
    cyc(40);
    press(6, 6);
    cyc(20);
    press(6, 6);

    // Random enable/dir/button activity.
    seg = 0;
    for (int i = 0; i < 2000; i++) begin
      if (seg == 0) begin
        bus_if.mode_btn = ~bus_if.mode_btn;
        seg = $urandom_range(1, 25);
      end
      seg--;
      bus_if.enable = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 15) == 0) bus_if.dir = ~bus_if.dir;
      cyc(1);
    end
    bus_if.mode_btn = 1'b0;
    bus_if.enable = 1'b1;
    cyc(10);

    // Reach SCAN, then reset asynchronously while LED 2 is lit.
    for (int i = 0; i < 4; i++) if (m_mode != 2) press(6, 8);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #3;
      if (bus_if.gleds == 4'b0100) found = 1'b1;
    end
    check("scan_pos2_reached", int'(found), 1);
    reset_n = 1'b0;
    #1;
    check("async_reset_gleds", int'(bus_if.gleds), 0);
    check("async_reset_rled", int'(bus_if.rled), 0);
    check("async_reset_tick", int'(bus_if.tick), 0);
    cyc(3);
    bus_if.dir = 1'b0;
    reset_n = 1'b1;
    cyc(20);

    bus_if.enable = 1'b0;
    cyc(5);
    check("queue_drained", expq.size(), 0);
    check("tick_count", mon_ticks, m_ticks);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
